// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: a - b computed LSB first, one bit per clock,
// with a busy/done handshake and registered result and borrow outputs.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] differ,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             busy_q, busy_d, done_q, done_d, borrow_q, borrow_d;
    logic             accept, last_bit, d_bit, bout;

    // start is only honoured outside SHIFT, so a running operation cannot be disturbed
    assign accept   = (state_q != SHIFT) && start;
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign d_bit    = a_q[0] ^ b_q[0] ^ bin_q;
    assign bout     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = accept ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        borrow_d = borrow_q;
        if (accept) begin
            a_d    = a;
            b_d    = b;
            bin_d  = 1'b0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (state_q == SHIFT) begin
            // shift/OR form keeps the MSB insertion legal for WIDTH = 1
            res_d = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            bin_d = bout;
            cnt_d = cnt_q + CW'(1);
            if (last_bit) begin
                busy_d   = 1'b0;
                done_d   = 1'b1;
                borrow_d = bout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign differ = res_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: WIDTH=8 and WIDTH=1 instances, directed
// scenarios plus random operations compared against an arithmetic model.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, differ8;
    logic [0:0] a1 = '0, b1 = '0, differ1;
    logic       busy8, done8, borrow8, busy1, done1, borrow1;
    int         n_vec = 0, n_err = 0;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .differ(differ8), .borrow(borrow8)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .differ(differ1), .borrow(borrow1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 operation; inj>0 pulses start with junk operands in that SHIFT cycle.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input int inj);
        int edges, busy_n;
        logic [7:0] exp_d;
        logic       exp_b;
        exp_d = x - y;
        exp_b = (x < y);
        @(negedge clk);
        start8 = 1'b1; a8 = x; b8 = y;
        @(posedge clk);
        edges = 1;
        busy_n = 0;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        while (!done8 && edges < 20) begin
            if (busy8) busy_n++;
            start8 = (inj > 0 && busy_n == inj);
            a8 = 8'($urandom); b8 = 8'($urandom);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        start8 = 1'b0;
        check("latency8", 32'(edges), 32'd9);
        check("busy_cycles8", 32'(busy_n), 32'd8);
        check("differ8", 32'(differ8), 32'(exp_d));
        check("borrow8", 32'(borrow8), 32'(exp_b));
        check("busy_in_done8", 32'(busy8), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("done_pulse8", 32'(done8), 32'd0);
        check("differ_hold8", 32'(differ8), 32'(exp_d));
    endtask

    task automatic op1(input logic x, input logic y, input logic exp_d, input logic exp_b);
        int edges, busy_n;
        @(negedge clk);
        start1 = 1'b1; a1 = x; b1 = y;
        @(posedge clk);
        edges = 1;
        busy_n = 0;
        @(negedge clk);
        start1 = 1'b0; a1 = ~x; b1 = ~y;
        while (!done1 && edges < 10) begin
            if (busy1) busy_n++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency1", 32'(edges), 32'd2);
        check("busy_cycles1", 32'(busy_n), 32'd1);
        check("differ1", 32'(differ1), 32'(exp_d));
        check("borrow1", 32'(borrow1), 32'(exp_b));
    endtask

    initial begin
        int edges, idx, last, dones;
        logic [7:0] qa[3] = '{8'h05, 8'h03, 8'h80};
        logic [7:0] qb[3] = '{8'h03, 8'h05, 8'h80};
        logic [7:0] xa, xb;

        #2;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_differ", 32'(differ8), 32'd0);
        check("rst_borrow", 32'(borrow8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        op8(8'h5A, 8'h23, 0);
        op8(8'h10, 8'h20, 0);
        op8(8'h00, 8'h01, 0);
        op8(8'hFF, 8'hFF, 0);
        op8(8'h00, 8'h00, 0);
        op8(8'hC3, 8'h3C, 3);

        // Reset in the 4th SHIFT cycle aborts the operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h23;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_rst", 32'(busy8), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy8), 32'd0);
        check("async_rst_differ", 32'(differ8), 32'd0);
        check("async_rst_borrow", 32'(borrow8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check("no_done_after_abort", 32'(dones), 32'd0);
        op8(8'h09, 8'h04, 0);

        // start held high: three back-to-back operations.
        @(negedge clk);
        a8 = qa[0]; b8 = qb[0]; start8 = 1'b1;
        idx = 0; edges = 0; last = 0;
        while (idx < 3 && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done8) begin
                xa = qa[idx]; xb = qb[idx];
                check("b2b_spacing", 32'(edges - last), 32'd9);
                check("b2b_differ", 32'(differ8), 32'(8'(xa - xb)));
                check("b2b_borrow", 32'(borrow8), 32'(xa < xb));
                last = edges;
                idx++;
                if (idx < 3) begin
                    a8 = qa[idx]; b8 = qb[idx];
                end else begin
                    start8 = 1'b0;
                end
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
        check("b2b_count", 32'(idx), 32'd3);
        @(negedge clk);

        for (int i = 0; i < 25; i++)
            op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 7)));

        op1(1'b0, 1'b0, 1'b0, 1'b0);
        op1(1'b0, 1'b1, 1'b1, 1'b1);
        op1(1'b1, 1'b0, 1'b1, 1'b0);
        op1(1'b1, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction, sampled on a rising edge.
REQ-005 SHALL have port a, input, WIDTH bits: the minuend, unsigned, sampled only on an accepted start.
REQ-006 SHALL have port b, input, WIDTH bits: the subtrahend, unsigned, sampled only on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high while bit-serial processing is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse that marks the result as valid.
REQ-009 SHALL have port differ, output, WIDTH bits: the result (a - b) mod 2^WIDTH.
REQ-010 SHALL have port borrow, output, 1 bit: the final borrow-out, high exactly when a < b (unsigned).

Function
REQ-011 SHALL implement an FSM with states IDLE, SHIFT and DONE, all outputs registered.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL be accepted, with these effects:
- a and b load into internal shift registers.
- The borrow flip-flop clears to 0.
- The bit counter clears to 0.
- The FSM moves to SHIFT.
REQ-013 In SHIFT, each rising edge SHALL process one bit, LSB first. With operand bits ai, bi and stored borrow bin:
- difference bit d = ai ^ bi ^ bin
- new borrow = (~ai & bi) | (~(ai ^ bi) & bin)
REQ-014 On each SHIFT edge, d SHALL shift into the MSB of the result register, both operand registers SHALL shift right by one, and the counter SHALL increment.
REQ-015 On the SHIFT edge that processes bit WIDTH-1, the FSM SHALL move to DONE.
REQ-016 Timing of a subtraction:
- Latency: done is high in the cycle after the (WIDTH+1)th rising edge, counting the accepting edge as the first.
- busy is high for exactly WIDTH cycles.
- done is high for exactly one cycle.
REQ-017 In DONE with start=0, the FSM SHALL return to IDLE on the next edge.
REQ-018 start SHALL be ignored while in SHIFT; operands and progress SHALL be unaffected.
REQ-019 differ and borrow SHALL hold their last completed result from the DONE cycle until the next accepted start completes.
- During SHIFT, differ shows partial shift contents and is not valid.
- borrow changes only on entry to DONE.
REQ-020 Changes on a and b SHALL have no effect except on the accepting edge.
REQ-021 With WIDTH=1, the block SHALL behave as a registered half subtractor.
- Results: 0-0 -> 0/0; 0-1 -> 1/1; 1-0 -> 1/0; 1-1 -> 0/0 (differ/borrow).
- done is high 2 edges after start is accepted.
REQ-022 start held high continuously SHALL start a new subtraction from each DONE state, giving back-to-back operations with no IDLE cycle between them.

Reset
REQ-023 While rst_n=0, the block SHALL immediately, independent of clk, set:
- FSM to IDLE.
- busy=0, done=0, differ=0, borrow=0.
- Counter, operand registers and borrow flip-flop to 0.
REQ-024 When rst_n asserts during SHIFT or DONE, the block SHALL abort the operation and produce no done pulse.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-026 A bench SHALL cover these directed scenarios, with WIDTH=8 unless stated:
- a=0x5A, b=0x23, start pulse -> done after 9 edges, differ=0x37, borrow=0, busy high 8 cycles.
- Sweep of operand pairs -> results:
  - 0x10-0x20 -> differ=0xF0, borrow=1
  - 0x00-0x01 -> differ=0xFF, borrow=1
  - 0xFF-0xFF -> differ=0x00, borrow=0
  - 0x00-0x00 -> differ=0x00, borrow=0
- start asserted in cycle 3 of SHIFT with different a and b -> ignored, original result produced, a single done pulse.
- rst_n pulled low in the 4th SHIFT cycle -> outputs 0 immediately, no done; a new operation 0x09-0x04 then gives differ=0x05, borrow=0.
- start held high for 3 operations (0x05-0x03, 0x03-0x05, 0x80-0x80) -> done pulses spaced 9 cycles apart, giving 0x02/0, 0xFE/1, 0x00/0.
- WIDTH=1 instance, all four input pairs -> the half-subtractor truth table from REQ-021, each done 2 edges after acceptance.
